// File: rtl/logic_seq_pkg.sv
// Shared types and default sizing for the logic-unit operation sequencer.
package logic_seq_pkg;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_e;

  // Default datapath sizing
  localparam int DEF_WIDTH   = 64;
  localparam int DEF_SEL_W   = 3;
  localparam int DEF_NUM_OPS = 8;

endpackage

// File: rtl/next_op_pick.sv
// Picks the next select code to issue after cur_sel, given the set of
// enabled codes. With an all-ones mask this reduces to increment and a
// compare against NUM_OPS-1.
module next_op_pick
  import logic_seq_pkg::*;
#(
  parameter int SEL_W   = DEF_SEL_W,
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic [SEL_W-1:0]   cur_sel,
  input  logic [NUM_OPS-1:0] mask,
  output logic [SEL_W-1:0]   next_sel,
  output logic               is_last
);

  // lowest enabled code strictly above cur_sel; none left means cur_sel is last
  always_comb begin
    next_sel = cur_sel;
    is_last  = 1'b1;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (mask[i] && (i > int'(cur_sel))) begin
        next_sel = SEL_W'(i);
        is_last  = 1'b0;
      end
    end
  end

endmodule

// File: rtl/logic_op_sequencer.sv
// Hardware initiator for the external combinational logic unit.
// Accepts one operand pair, steps lu_sel through the enabled select codes
// in ascending order, registers each result and streams it out.
// Optional feature macro: LOGIC_OP_SEQUENCER_OP_MASK_EN adds an op_mask
// input that selects which codes are issued (all-zero mask = all codes).
module logic_op_sequencer
  import logic_seq_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int SEL_W   = DEF_SEL_W,
  parameter int NUM_OPS = DEF_NUM_OPS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
`ifdef LOGIC_OP_SEQUENCER_OP_MASK_EN
  input  logic [NUM_OPS-1:0] op_mask,
`endif
  output logic [WIDTH-1:0]   lu_in1,
  output logic [WIDTH-1:0]   lu_in2,
  output logic [SEL_W-1:0]   lu_sel,
  input  logic [WIDTH-1:0]   lu_out,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_last
);

  localparam logic [NUM_OPS-1:0] FULL_MASK = {NUM_OPS{1'b1}};

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   lu_in1_q, lu_in1_d;
  logic [WIDTH-1:0]   lu_in2_q, lu_in2_d;
  logic [SEL_W-1:0]   lu_sel_q, lu_sel_d;
  logic [WIDTH-1:0]   out_data_q, out_data_d;
  logic [SEL_W-1:0]   out_sel_q, out_sel_d;
  logic               out_valid_q, out_valid_d;
  logic               out_last_q, out_last_d;

  logic [NUM_OPS-1:0] held_mask;
  logic [SEL_W-1:0]   first_sel;
  logic [SEL_W-1:0]   next_sel;
  logic               cur_is_last;

`ifdef LOGIC_OP_SEQUENCER_OP_MASK_EN
  logic [NUM_OPS-1:0] mask_q, mask_d;
  logic [NUM_OPS-1:0] acc_mask;

  assign acc_mask  = (op_mask == '0) ? FULL_MASK : op_mask;
  assign held_mask = mask_q;

  // first code of a transaction is the lowest bit set in the accepted mask
  always_comb begin
    first_sel = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (acc_mask[i]) first_sel = SEL_W'(i);
    end
  end
`else
  assign held_mask = FULL_MASK;
  assign first_sel = '0;
`endif

  next_op_pick #(
    .SEL_W   (SEL_W),
    .NUM_OPS (NUM_OPS)
  ) u_next_op_pick (
    .cur_sel  (lu_sel_q),
    .mask     (held_mask),
    .next_sel (next_sel),
    .is_last  (cur_is_last)
  );

  // in_ready is forced low while reset is asserted, not just after it
  assign in_ready = (state_q == IDLE) && !rst;

  // next-state and next-output computation for the IDLE/ISSUE/RESP sequence
  always_comb begin
    state_d     = state_q;
    lu_in1_d    = lu_in1_q;
    lu_in2_d    = lu_in2_q;
    lu_sel_d    = lu_sel_q;
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
`ifdef LOGIC_OP_SEQUENCER_OP_MASK_EN
    mask_d      = mask_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          lu_in1_d = in_a;
          lu_in2_d = in_b;
          lu_sel_d = first_sel;
`ifdef LOGIC_OP_SEQUENCER_OP_MASK_EN
          mask_d   = acc_mask;
`endif
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        out_data_d  = lu_out;
        out_sel_d   = lu_sel_q;
        out_last_d  = cur_is_last;
        out_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (out_last_q) begin
            state_d = IDLE;
          end else begin
            lu_sel_d = next_sel;
            state_d  = ISSUE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers; reset aborts any transaction in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lu_in1_q    <= '0;
      lu_in2_q    <= '0;
      lu_sel_q    <= '0;
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef LOGIC_OP_SEQUENCER_OP_MASK_EN
      mask_q      <= FULL_MASK;
`endif
    end else begin
      state_q     <= state_d;
      lu_in1_q    <= lu_in1_d;
      lu_in2_q    <= lu_in2_d;
      lu_sel_q    <= lu_sel_d;
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
`ifdef LOGIC_OP_SEQUENCER_OP_MASK_EN
      mask_q      <= mask_d;
`endif
    end
  end

  assign lu_in1    = lu_in1_q;
  assign lu_in2    = lu_in2_q;
  assign lu_sel    = lu_sel_q;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
